// File: rtl/decode_stage_pipe.sv
// SimpleRISC decode stage: field/flag/immediate decode buffered in a DEPTH-entry valid/ready FIFO.
// Optional RAW scoreboard with writeback ports is enabled by defining DECODE_SCOREBOARD_EN.
module decode_stage_pipe #(
  parameter int INSTR_W = 32,
  parameter int RADDR_W = 4,
  parameter int RA_REG  = 15,
  parameter int DEPTH   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [RADDR_W-1:0] rs1,
  output logic [RADDR_W-1:0] rs2,
  output logic [RADDR_W-1:0] rd,
  output logic               use_rs1,
  output logic               use_rs2,
  output logic               wr_rd,
  output logic               is_imm,
  output logic [31:0]        imm,
`ifdef DECODE_SCOREBOARD_EN
  input  logic               wb_valid,
  input  logic [RADDR_W-1:0] wb_rd,
`endif
  output logic [4:0]         op
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [RADDR_W-1:0] rs1;
    logic [RADDR_W-1:0] rs2;
    logic [RADDR_W-1:0] rd;
    logic               use_rs1;
    logic               use_rs2;
    logic               wr_rd;
    logic               is_imm;
    logic [31:0]        imm;
    logic [4:0]         op;
  } entry_t;

  logic [4:0]         opc;
  logic               i_bit;
  logic [RADDR_W-1:0] f_rd;
  logic [RADDR_W-1:0] f_rs1;
  logic [RADDR_W-1:0] f_rs2;
  logic [31:0]        mod_imm;
  logic [31:0]        off_imm;
  entry_t             dec;

  assign opc     = instr[31:27];
  assign i_bit   = instr[26];
  assign f_rd    = RADDR_W'(instr[25:22]);
  assign f_rs1   = RADDR_W'(instr[21:18]);
  assign f_rs2   = RADDR_W'(instr[17:14]);
  assign off_imm = {{5{instr[26]}}, instr[26:0]};

  always_comb begin
    mod_imm = {{16{instr[15]}}, instr[15:0]};
    case (instr[17:16])
      2'b01:   mod_imm = {16'h0000, instr[15:0]};
      2'b10:   mod_imm = {instr[15:0], 16'h0000};
      default: mod_imm = {{16{instr[15]}}, instr[15:0]};
    endcase
  end

  // Unused fields stay zero; undefined opcodes fall through as nop.
  always_comb begin
    dec    = '0;
    dec.op = opc;
    case (opc)
      5'b00101: begin
        dec.rs1     = f_rs1;
        dec.use_rs1 = 1'b1;
        dec.rs2     = i_bit ? '0 : f_rs2;
        dec.use_rs2 = !i_bit;
        dec.is_imm  = i_bit;
        dec.imm     = i_bit ? mod_imm : 32'h0;
      end
      5'b01000, 5'b01001: begin
        dec.rd      = f_rd;
        dec.wr_rd   = 1'b1;
        dec.rs2     = i_bit ? '0 : f_rs2;
        dec.use_rs2 = !i_bit;
        dec.is_imm  = i_bit;
        dec.imm     = i_bit ? mod_imm : 32'h0;
      end
      5'b01101: ;
      5'b01110: begin
        dec.rd      = f_rd;
        dec.wr_rd   = 1'b1;
        dec.rs1     = f_rs1;
        dec.use_rs1 = 1'b1;
        dec.is_imm  = 1'b1;
        dec.imm     = mod_imm;
      end
      5'b01111: begin
        dec.rs1     = f_rs1;
        dec.use_rs1 = 1'b1;
        dec.rs2     = f_rd;
        dec.use_rs2 = 1'b1;
        dec.is_imm  = 1'b1;
        dec.imm     = mod_imm;
      end
      5'b10000, 5'b10001, 5'b10010: dec.imm = off_imm;
      5'b10011: begin
        dec.rd    = RADDR_W'(RA_REG);
        dec.wr_rd = 1'b1;
        dec.imm   = off_imm;
      end
      5'b10100: begin
        dec.rs1     = RADDR_W'(RA_REG);
        dec.use_rs1 = 1'b1;
      end
      default: begin
        if (opc <= 5'b01100) begin
          dec.rd      = f_rd;
          dec.wr_rd   = 1'b1;
          dec.rs1     = f_rs1;
          dec.use_rs1 = 1'b1;
          dec.rs2     = i_bit ? '0 : f_rs2;
          dec.use_rs2 = !i_bit;
          dec.is_imm  = i_bit;
          dec.imm     = i_bit ? mod_imm : 32'h0;
        end
      end
    endcase
  end

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   wptr_reg;
  logic [PTR_W-1:0]   rptr_reg;
  logic [CNT_W-1:0]   count_reg;
  logic               full;
  logic               push;
  logic               pop;
  logic               stall;
  entry_t             head;

  assign full      = (count_reg == CNT_W'(DEPTH));
  assign out_valid = (count_reg != '0);
  assign pop       = out_valid && out_ready;
  assign push      = in_valid && in_ready;
  // A pop in the same cycle frees a slot, so a full FIFO still streams one-in/one-out.
  assign in_ready  = (!full || out_ready) && !stall;

`ifdef DECODE_SCOREBOARD_EN
  logic [2**RADDR_W-1:0] pending_reg;

  generate
    for (genvar gi = 0; gi < 2**RADDR_W; gi++) begin : g_pending
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          pending_reg[gi] <= 1'b0;
        end else if (flush) begin
          pending_reg[gi] <= 1'b0;
        end else if (push && dec.wr_rd && (dec.rd == RADDR_W'(gi))) begin
          pending_reg[gi] <= 1'b1;
        end else if (wb_valid && (wb_rd == RADDR_W'(gi))) begin
          pending_reg[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  assign stall = (dec.use_rs1 && pending_reg[dec.rs1]) ||
                 (dec.use_rs2 && pending_reg[dec.rs2]);
`else
  assign stall = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr_reg] <= dec;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_reg  <= '0;
      rptr_reg  <= '0;
      count_reg <= '0;
    end else if (flush) begin
      wptr_reg  <= '0;
      rptr_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (push) wptr_reg <= wptr_reg + PTR_W'(1);
      if (pop)  rptr_reg <= rptr_reg + PTR_W'(1);
      if (push && !pop)      count_reg <= count_reg + CNT_W'(1);
      else if (!push && pop) count_reg <= count_reg - CNT_W'(1);
    end
  end

  // Empty FIFO presents zeros so stale or unwritten entries never leak out.
  assign head    = out_valid ? mem[rptr_reg] : '0;
  assign rs1     = head.rs1;
  assign rs2     = head.rs2;
  assign rd      = head.rd;
  assign use_rs1 = head.use_rs1;
  assign use_rs2 = head.use_rs2;
  assign wr_rd   = head.wr_rd;
  assign is_imm  = head.is_imm;
  assign imm     = head.imm;
  assign op      = head.op;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Directed bench for decode_stage_pipe (DEPTH=2): decode table, immediate modes, FIFO full/stream/flush/reset.
module tb_decode_stage_pipe;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instr = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  rs1, rs2, rd;
  logic        use_rs1, use_rs2, wr_rd, is_imm;
  logic [31:0] imm;
  logic [4:0]  op;
`ifdef DECODE_SCOREBOARD_EN
  logic        wb_valid = 1'b0;
  logic [3:0]  wb_rd = '0;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  decode_stage_pipe #(.INSTR_W(32), .RADDR_W(4), .RA_REG(15), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .out_valid(out_valid), .out_ready(out_ready),
    .rs1(rs1), .rs2(rs2), .rd(rd), .use_rs1(use_rs1), .use_rs2(use_rs2),
    .wr_rd(wr_rd), .is_imm(is_imm), .imm(imm),
`ifdef DECODE_SCOREBOARD_EN
    .wb_valid(wb_valid), .wb_rd(wb_rd),
`endif
    .op(op)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_one(input logic [31:0] word);
    in_valid = 1'b1;
    instr    = word;
    @(negedge clk);
    in_valid = 1'b0;
    $display("push instr=%h", word);
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    $display("pop");
  endtask

  function automatic logic [31:0] add_rd(input int k);
    return 32'h00C48000 & 32'hFC3FFFFF | (32'(k) << 22);
  endfunction

  initial begin
    // Reset state
    @(negedge clk); @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_rd", rd, 0);
    chk("rst_imm", imm, 0);
    rst = 1'b1;
    @(negedge clk);

    // 1: add r3,r1,r2
    push_one(32'h00C48000);
    chk("add_valid", out_valid, 1);
    chk("add_rd", rd, 3);
    chk("add_rs1", rs1, 1);
    chk("add_rs2", rs2, 2);
    chk("add_wr_rd", wr_rd, 1);
    chk("add_is_imm", is_imm, 0);
    chk("add_use_rs2", use_rs2, 1);
    chk("add_op", op, 0);
    pop_one();
    chk("add_drained", out_valid, 0);

    // 2: mov r5,#0xFFFF with each modifier
    push_one(32'h4D40FFFF);
    chk("mov00_imm", imm, 32'hFFFFFFFF);
    chk("mov_rd", rd, 5);
    chk("mov_use_rs1", use_rs1, 0);
    chk("mov_use_rs2", use_rs2, 0);
    chk("mov_is_imm", is_imm, 1);
    pop_one();
    push_one(32'h4D41FFFF);
    chk("mov01_imm", imm, 32'h0000FFFF);
    pop_one();
    push_one(32'h4D42FFFF);
    chk("mov10_imm", imm, 32'hFFFF0000);
    pop_one();
    push_one(32'h4D43FFFF);
    chk("mov11_imm", imm, 32'hFFFFFFFF);
    pop_one();

    // 3: fill with out_ready=0, extra pushes ignored, order preserved
    push_one(add_rd(1));
    chk("fill1_in_ready", in_ready, 1);
    push_one(add_rd(2));
    chk("fill2_in_ready", in_ready, 0);
    in_valid = 1'b1;
    instr    = add_rd(7);
    @(negedge clk); @(negedge clk);
    in_valid = 1'b0;
    chk("full_head_rd", rd, 1);
    chk("full_in_ready", in_ready, 0);
    out_ready = 1'b1;
    @(negedge clk);
    chk("drain_rd2", rd, 2);
    @(negedge clk);
    chk("drain_empty", out_valid, 0);
    out_ready = 1'b0;

    // 4: full FIFO streaming push+pop for 10 cycles
    push_one(add_rd(1));
    push_one(add_rd(2));
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      instr = add_rd(3 + i);
      @(negedge clk);
      $display("stream cycle=%0d head_rd=%0d", i, rd);
      chk("stream_rd", rd, 32'(2 + i));
      chk("stream_valid", out_valid, 1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("stream_still_full", in_ready, 0);
    chk("stream_head", rd, 11);
    pop_one();
    chk("stream_tail", rd, 12);
    pop_one();
    chk("stream_empty", out_valid, 0);

    // 5: call/ret/branch/store/undefined
    push_one(32'h9FFFFFFC);
    chk("call_rd", rd, 15);
    chk("call_wr_rd", wr_rd, 1);
    chk("call_imm", imm, 32'hFFFFFFFC);
    chk("call_op", op, 5'h13);
    pop_one();
    push_one(32'hA0000000);
    chk("ret_rs1", rs1, 15);
    chk("ret_use_rs1", use_rs1, 1);
    chk("ret_rd", rd, 0);
    chk("ret_wr_rd", wr_rd, 0);
    pop_one();
    push_one(32'h80000008);
    chk("beq_imm", imm, 8);
    chk("beq_wr_rd", wr_rd, 0);
    pop_one();
    push_one(32'h79891234);
    chk("st_rs1", rs1, 2);
    chk("st_rs2", rs2, 6);
    chk("st_rd", rd, 0);
    chk("st_use_rs2", use_rs2, 1);
    chk("st_is_imm", is_imm, 1);
    chk("st_imm", imm, 32'h00001234);
    pop_one();
    push_one(32'hF8FFFFFF);
    chk("undef_wr_rd", wr_rd, 0);
    chk("undef_rd", rd, 0);
    chk("undef_use_rs1", use_rs1, 0);
    chk("undef_imm", imm, 0);
    pop_one();

    // 6: flush with push and pop requested in the same cycle
    push_one(add_rd(1));
    push_one(add_rd(2));
    flush     = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    instr     = add_rd(9);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("flush_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    @(negedge clk);
    chk("flush_no_emit", out_valid, 0);

    // Async reset mid-transfer
    push_one(add_rd(4));
    rst = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_rd", rd, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("arst_stays_empty", out_valid, 0);

`ifdef DECODE_SCOREBOARD_EN
    out_ready = 1'b1;
    push_one(32'h00C48000);
    in_valid = 1'b1;
    instr    = 32'h090C4000;
    #1;
    chk("sb_stall", in_ready, 0);
    @(negedge clk);
    chk("sb_stall_hold", in_ready, 0);
    wb_valid = 1'b1;
    wb_rd    = 4'd3;
    @(negedge clk);
    wb_valid = 1'b0;
    chk("sb_release", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("sb_pushed_rd", rd, 4);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
